smemory_sync_be: RTL and testbench
==================================

// Module: smemory_sync_be
// PURPOSE
//  Single-clock simple dual-port RAM: one write port with per-lane byte enables, one read port.
//  Configurable read latency, read-valid strobe, range-checked addresses.
//  Storage primitive for the single-clock FIFO and for buffers that need partial-word updates.
// PARAMETERS
//  SIZE_DATA   32  word width in bits; must be a multiple of SIZE_LANE
//  SIZE_LANE   8   bits per write-enable lane; NUM_LANE = SIZE_DATA/SIZE_LANE (localparam)
//  SIZE_DEPTH  16  number of words; must satisfy 2 <= SIZE_DEPTH <= 2**SIZE_ADDR
//  SIZE_ADDR   4   address width
//  RD_LATENCY  1   1 or 2 cycles from i_rd_en to o_rd_valid; any other value is a $error at elaboration
// PORTS
//  i_clk       in   1          single clock, rising edge
//  i_rst       in   1          asynchronous, active-high reset
//  i_rd_en     in   1          read request this cycle
//  i_addr_rd   in   SIZE_ADDR  read address
//  o_data_rd   out  SIZE_DATA  read data, meaningful when o_rd_valid=1
//  o_rd_valid  out  1          o_data_rd carries the result of a read issued RD_LATENCY cycles ago
//  o_rd_oor    out  1          qualifies o_rd_valid: that read's address was >= SIZE_DEPTH
//  i_wr_en     in   1          write request this cycle
//  i_wr_be     in   NUM_LANE   lane enables; bit k writes bits [k*SIZE_LANE +: SIZE_LANE]
//  i_addr_wr   in   SIZE_ADDR  write address
//  i_data_wr   in   SIZE_DATA  write data
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - o_data_rd=0, o_rd_valid=0, o_rd_oor=0, and every pipeline stage valid bit cleared.
//   - Memory array is NOT reset; contents are undefined until written.
//  Write:
//   - On a rising edge with i_wr_en=1 and i_addr_wr<SIZE_DEPTH, update only the lanes with i_wr_be[k]=1.
//   - i_wr_be=0 is a legal no-op.
//   - i_addr_wr>=SIZE_DEPTH: write dropped silently; array unchanged.
//  Read, RD_LATENCY=1:
//   - Edge N with i_rd_en=1 -> o_data_rd=mem[i_addr_rd] and o_rd_valid=1 after edge N.
//  Read, RD_LATENCY=2:
//   - Edge N captures the array word into stage 1; edge N+1 moves it to o_data_rd and asserts o_rd_valid.
//   - Fully pipelined: one read per cycle, back-to-back, no bubbles.
//  Read valid and hold:
//   - o_rd_valid is a 1-cycle pulse per read.
//   - o_data_rd holds its last value when no read completes; it never returns to 0 except on reset.
//  Out-of-range read (i_addr_rd>=SIZE_DEPTH):
//   - o_rd_valid still pulses, o_rd_oor=1, o_data_rd=0.
//   - o_rd_oor is 0 whenever o_rd_valid=0.
//  Same-cycle read and write to the same in-range address: see CONFIGURATION.
//  Write-after-read-issue (RD_LATENCY=2):
//   - A write landing between issue and output is not visible to that read; stage 1 holds the snapshot.
//  i_rd_en while i_rst=1: ignored; no o_rd_valid is produced for it after release.
//  Reset asserted mid-pipeline: in-flight reads are discarded; no o_rd_valid after release for them.
// CONFIGURATION
//  Macro SMEM_WR_BYPASS_EN applies when i_rd_en and i_wr_en are both 1 and i_addr_rd==i_addr_wr<SIZE_DEPTH.
//  Defined (write-first):
//   - Read returns a per-lane merge: lanes with i_wr_be[k]=1 take i_data_wr, other lanes keep old mem.
//  Undefined (read-first):
//   - Read returns the pre-write word; the array still takes the write.
//   - Maps directly onto vendor block RAM.
//  Applies identically for both RD_LATENCY values; the merge happens at issue, before stage 1.
// TESTING  (SIZE_DATA=32, SIZE_LANE=8, SIZE_DEPTH=12, SIZE_ADDR=4)
//  1. Write 0xA5A5_0001 @3 (be=F); read @3 next cycle.
//     -> RD_LATENCY=1: valid 1 cycle after issue, data 0xA5A5_0001.
//     -> RD_LATENCY=2: valid 2 cycles after issue, same data.
//  2. Write 0x1122_3344 @5 (be=F), then 0xFFFF_FFFF @5 with be=0101b; read @5
//     -> 0x11FF_33FF.
//  3. Write @12 and @15; read @12.
//     -> valid=1, oor=1, data=0; reads of @0..11 unchanged.
//  4. mem[7]=0x0000_0000, then same-cycle read+write @7 with 0xDEAD_BEEF, be=0011b
//     -> with SMEM_WR_BYPASS_EN: data 0x0000_BEEF; without: 0x0000_0000.
//     -> a follow-up read of @7 returns 0x0000_BEEF in both builds.
//  5. RD_LATENCY=2: reads issued on 4 consecutive cycles @0,1,2,3
//     -> 4 consecutive valid pulses, data in issue order.
//     -> pulse i_rst with 2 reads in flight: outputs 0, no stale valid after release.
//  6. No reads for 10 cycles after a read returned 0xCAFE_F00D
//     -> o_data_rd stays 0xCAFE_F00D, o_rd_valid stays 0.

Source files
------------

// File: rtl/smemory_sync_be_if.sv
// Bus bundle for smemory_sync_be: read request/response and byte-enabled write port.
// The master drives requests; the slave (the RAM) returns read data, valid and out-of-range flags.
interface smemory_sync_be_if #(
  parameter int SIZE_DATA = 32,
  parameter int SIZE_LANE = 8,
  parameter int SIZE_ADDR = 4
);
  localparam int NUM_LANE = SIZE_DATA / SIZE_LANE;

  logic                 i_rd_en;
  logic [SIZE_ADDR-1:0] i_addr_rd;
  logic [SIZE_DATA-1:0] o_data_rd;
  logic                 o_rd_valid;
  logic                 o_rd_oor;
  logic                 i_wr_en;
  logic [NUM_LANE-1:0]  i_wr_be;
  logic [SIZE_ADDR-1:0] i_addr_wr;
  logic [SIZE_DATA-1:0] i_data_wr;

  modport master (
    output i_rd_en, i_addr_rd, i_wr_en, i_wr_be, i_addr_wr, i_data_wr,
    input  o_data_rd, o_rd_valid, o_rd_oor
  );

  modport slave (
    input  i_rd_en, i_addr_rd, i_wr_en, i_wr_be, i_addr_wr, i_data_wr,
    output o_data_rd, o_rd_valid, o_rd_oor
  );
endinterface

// File: rtl/smemory_sync_be.sv
// Single-clock simple dual-port RAM with per-lane write enables, 1- or 2-cycle read latency.
// Optional macro SMEM_WR_BYPASS_EN: same-address read+write returns the merged (write-first) word.
module smemory_sync_be #(
  parameter int SIZE_DATA  = 32,
  parameter int SIZE_LANE  = 8,
  parameter int SIZE_DEPTH = 16,
  parameter int SIZE_ADDR  = 4,
  parameter int RD_LATENCY = 1
) (
  input logic              i_clk,
  input logic              i_rst,
  smemory_sync_be_if.slave bus
);

  localparam int NUM_LANE = SIZE_DATA / SIZE_LANE;
  localparam logic [SIZE_ADDR:0] DEPTH_W = (SIZE_ADDR + 1)'(SIZE_DEPTH);

  if ((SIZE_DATA % SIZE_LANE) != 0) begin : g_bad_lane
    $error("smemory_sync_be: SIZE_DATA must be a multiple of SIZE_LANE");
  end
  if ((SIZE_DEPTH < 2) || (SIZE_DEPTH > (2 ** SIZE_ADDR))) begin : g_bad_depth
    $error("smemory_sync_be: SIZE_DEPTH must lie in [2, 2**SIZE_ADDR]");
  end

  logic [SIZE_DATA-1:0] mem_q [SIZE_DEPTH];

  logic                 wr_in_range_s;
  logic                 rd_in_range_s;
  logic                 rd_fire_s;
  logic [SIZE_DATA-1:0] rd_word_s;
  logic [SIZE_DATA-1:0] iss_data_s;
  logic                 iss_oor_s;

  logic                 src_valid_s;
  logic                 src_oor_s;
  logic [SIZE_DATA-1:0] src_data_s;

  logic [SIZE_DATA-1:0] data_rd_d, data_rd_q;
  logic                 rd_valid_d, rd_valid_q;
  logic                 rd_oor_d, rd_oor_q;

  // Address range qualification; widened by one bit so SIZE_DEPTH == 2**SIZE_ADDR works.
  always_comb begin
    wr_in_range_s = ({1'b0, bus.i_addr_wr} < DEPTH_W);
    rd_in_range_s = ({1'b0, bus.i_addr_rd} < DEPTH_W);
    rd_fire_s     = bus.i_rd_en;
  end

  // Issue-stage word: array snapshot (zero when out of range), optionally merged with the same-cycle write.
  always_comb begin
    rd_word_s  = '0;
    iss_data_s = '0;
    iss_oor_s  = ~rd_in_range_s;
    if (rd_in_range_s) begin
      rd_word_s = mem_q[bus.i_addr_rd];
    end else begin
      rd_word_s = '0;
    end
    iss_data_s = rd_word_s;
`ifdef SMEM_WR_BYPASS_EN
    if (bus.i_wr_en && wr_in_range_s && rd_in_range_s && (bus.i_addr_wr == bus.i_addr_rd)) begin
      for (int k = 0; k < NUM_LANE; k++) begin
        if (bus.i_wr_be[k]) begin
          iss_data_s[k*SIZE_LANE +: SIZE_LANE] = bus.i_data_wr[k*SIZE_LANE +: SIZE_LANE];
        end else begin
          iss_data_s[k*SIZE_LANE +: SIZE_LANE] = rd_word_s[k*SIZE_LANE +: SIZE_LANE];
        end
      end
    end else begin
      iss_data_s = rd_word_s;
    end
`endif
  end

  // Storage array: lane-granular writes, out-of-range writes dropped, never reset.
  always_ff @(posedge i_clk) begin
    if (bus.i_wr_en && wr_in_range_s) begin
      for (int k = 0; k < NUM_LANE; k++) begin
        if (bus.i_wr_be[k]) begin
          mem_q[bus.i_addr_wr][k*SIZE_LANE +: SIZE_LANE] <= bus.i_data_wr[k*SIZE_LANE +: SIZE_LANE];
        end
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                 s1_valid_d, s1_valid_q;
    logic                 s1_oor_d, s1_oor_q;
    logic [SIZE_DATA-1:0] s1_data_d, s1_data_q;

    // Stage 1 holds the issue-time snapshot so later writes cannot leak into the read.
    always_comb begin
      s1_valid_d = rd_fire_s;
      s1_oor_d   = rd_fire_s & iss_oor_s;
      s1_data_d  = s1_data_q;
      if (rd_fire_s) begin
        s1_data_d = iss_data_s;
      end else begin
        s1_data_d = s1_data_q;
      end
    end

    // Stage 1 register; reset drops any in-flight read.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        s1_valid_q <= 1'b0;
        s1_oor_q   <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_oor_q   <= s1_oor_d;
        s1_data_q  <= s1_data_d;
      end
    end

    assign src_valid_s = s1_valid_q;
    assign src_oor_s   = s1_oor_q;
    assign src_data_s  = s1_data_q;
  end else if (RD_LATENCY == 1) begin : g_lat1
    assign src_valid_s = rd_fire_s;
    assign src_oor_s   = iss_oor_s;
    assign src_data_s  = iss_data_s;
  end else begin : g_bad_latency
    $error("smemory_sync_be: RD_LATENCY must be 1 or 2");
    assign src_valid_s = 1'b0;
    assign src_oor_s   = 1'b0;
    assign src_data_s  = '0;
  end

  // Output stage: pulse valid per completed read, hold data otherwise.
  always_comb begin
    rd_valid_d = src_valid_s;
    rd_oor_d   = src_valid_s & src_oor_s;
    data_rd_d  = data_rd_q;
    if (src_valid_s) begin
      data_rd_d = src_data_s;
    end else begin
      data_rd_d = data_rd_q;
    end
  end

  // Output registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      data_rd_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_oor_q   <= rd_oor_d;
      data_rd_q  <= data_rd_d;
    end
  end

  assign bus.o_data_rd  = data_rd_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_rd_oor   = rd_oor_q;

endmodule

// File: tb/tb_smemory_sync_be.sv
// Bench for smemory_sync_be: drives one stimulus stream into a latency-1 and a latency-2 instance,
// each checked against a reference memory model through its own expected-read queue.
module tb_smemory_sync_be;

  localparam int DEPTH = 12;

  typedef struct {
    logic [31:0] data;
    logic        oor;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic [3:0]  addr_rd = 4'd0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_be = 4'd0;
  logic [3:0]  addr_wr = 4'd0;
  logic [31:0] data_wr = 32'd0;

  logic [31:0] mdl [DEPTH];
  exp_t        sb [2][$];
  logic [31:0] last_data [2];
  logic [1:0]  obs_v, obs_oor;
  logic [31:0] obs_d [2];
  int          ncyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  smemory_sync_be_if #(.SIZE_DATA(32), .SIZE_LANE(8), .SIZE_ADDR(4)) bus1 ();
  smemory_sync_be_if #(.SIZE_DATA(32), .SIZE_LANE(8), .SIZE_ADDR(4)) bus2 ();

  assign bus1.i_rd_en = rd_en;   assign bus2.i_rd_en = rd_en;
  assign bus1.i_addr_rd = addr_rd; assign bus2.i_addr_rd = addr_rd;
  assign bus1.i_wr_en = wr_en;   assign bus2.i_wr_en = wr_en;
  assign bus1.i_wr_be = wr_be;   assign bus2.i_wr_be = wr_be;
  assign bus1.i_addr_wr = addr_wr; assign bus2.i_addr_wr = addr_wr;
  assign bus1.i_data_wr = data_wr; assign bus2.i_data_wr = data_wr;

  assign obs_v[0] = bus1.o_rd_valid;   assign obs_v[1] = bus2.o_rd_valid;
  assign obs_oor[0] = bus1.o_rd_oor;   assign obs_oor[1] = bus2.o_rd_oor;
  assign obs_d[0] = bus1.o_data_rd;    assign obs_d[1] = bus2.o_data_rd;

  smemory_sync_be #(.SIZE_DATA(32), .SIZE_LANE(8), .SIZE_DEPTH(DEPTH), .SIZE_ADDR(4), .RD_LATENCY(1))
    dut_l1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
  smemory_sync_be #(.SIZE_DATA(32), .SIZE_LANE(8), .SIZE_DEPTH(DEPTH), .SIZE_ADDR(4), .RD_LATENCY(2))
    dut_l2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

  task automatic chk(input string tag, input int p, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s lat%0d cyc%0d: observed %h expected %h", tag, p + 1, ncyc, obs, exp);
    end
  endtask

  // Expected word for a read issued together with the current write inputs.
  function automatic logic [31:0] model_read(input logic [3:0] ra);
    logic [31:0] w;
    w = 32'd0;
    if (ra < 4'(DEPTH)) begin
      w = mdl[ra];
`ifdef SMEM_WR_BYPASS_EN
      if (wr_en && (addr_wr == ra)) begin
        for (int k = 0; k < 4; k++) begin
          if (wr_be[k]) w[k*8 +: 8] = data_wr[k*8 +: 8];
        end
      end
`endif
    end
    return w;
  endfunction

  // Monitor and model: on each falling edge check outputs, then record what the next rising edge will do.
  initial begin
    exp_t e;
    last_data[0] = 32'd0;
    last_data[1] = 32'd0;
    forever begin
      @(negedge clk);
      ncyc++;
      for (int p = 0; p < 2; p++) begin
        if (rst) begin
          chk("rst_valid", p, 32'(obs_v[p]), 32'd0);
          chk("rst_oor", p, 32'(obs_oor[p]), 32'd0);
          chk("rst_data", p, obs_d[p], 32'd0);
          sb[p].delete();
          last_data[p] = 32'd0;
        end else if (obs_v[p]) begin
          if (sb[p].size() == 0) begin
            chk("spurious_valid", p, 32'(obs_v[p]), 32'd0);
          end else begin
            e = sb[p].pop_front();
            chk("rd_data", p, obs_d[p], e.data);
            chk("rd_oor", p, 32'(obs_oor[p]), 32'(e.oor));
            chk("rd_latency", p, 32'(ncyc), 32'(e.due));
          end
          last_data[p] = obs_d[p];
        end else begin
          chk("oor_idle", p, 32'(obs_oor[p]), 32'd0);
          chk("data_hold", p, obs_d[p], last_data[p]);
          if ((sb[p].size() != 0) && (sb[p][0].due <= ncyc)) begin
            chk("missing_valid", p, 32'(obs_v[p]), 32'd1);
            void'(sb[p].pop_front());
          end
        end
      end
      if (!rst && rd_en) begin
        for (int p = 0; p < 2; p++) begin
          e.data = model_read(addr_rd);
          e.oor  = (addr_rd >= 4'(DEPTH));
          e.due  = ncyc + p + 1;
          sb[p].push_back(e);
        end
      end
      if (wr_en && (addr_wr < 4'(DEPTH))) begin
        for (int k = 0; k < 4; k++) begin
          if (wr_be[k]) mdl[addr_wr][k*8 +: 8] = data_wr[k*8 +: 8];
        end
      end
    end
  end

  task automatic step(input logic re, input logic [3:0] ra, input logic we,
                      input logic [3:0] be, input logic [3:0] wa, input logic [31:0] wd);
    rd_en = re; addr_rd = ra; wr_en = we; wr_be = be; addr_wr = wa; data_wr = wd;
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    rd_en = 1'b0; wr_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Directed stimulus followed by a random mix.
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) step(1'b0, 4'd0, 1'b1, 4'hF, 4'(i), 32'h1000_0000 + 32'(i));

    step(1'b0, 4'd0, 1'b1, 4'hF, 4'd3, 32'hA5A5_0001);
    step(1'b1, 4'd3, 1'b0, 4'h0, 4'd0, 32'd0);
    idle(3);

    step(1'b0, 4'd0, 1'b1, 4'hF, 4'd5, 32'h1122_3344);
    step(1'b0, 4'd0, 1'b1, 4'b0101, 4'd5, 32'hFFFF_FFFF);
    step(1'b0, 4'd0, 1'b1, 4'b0000, 4'd5, 32'h0BAD_0BAD);
    step(1'b1, 4'd5, 1'b0, 4'h0, 4'd0, 32'd0);
    idle(3);

    step(1'b0, 4'd0, 1'b1, 4'hF, 4'd12, 32'hBAD0_0012);
    step(1'b0, 4'd0, 1'b1, 4'hF, 4'd15, 32'hBAD0_0015);
    step(1'b1, 4'd12, 1'b0, 4'h0, 4'd0, 32'd0);
    step(1'b1, 4'd15, 1'b0, 4'h0, 4'd0, 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 4'(i), 1'b0, 4'h0, 4'd0, 32'd0);
    idle(3);

    step(1'b0, 4'd0, 1'b1, 4'hF, 4'd7, 32'h0000_0000);
    step(1'b1, 4'd7, 1'b1, 4'b0011, 4'd7, 32'hDEAD_BEEF);
    step(1'b1, 4'd7, 1'b0, 4'h0, 4'd0, 32'd0);
    idle(3);

    for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 1'b0, 4'h0, 4'd0, 32'd0);
    idle(3);

    step(1'b1, 4'd0, 1'b0, 4'h0, 4'd0, 32'd0);
    rd_en = 1'b1; addr_rd = 4'd1;
    @(posedge clk);
    #1;
    rst = 1'b1; addr_rd = 4'd2;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; rd_en = 1'b0;
    idle(4);

    step(1'b0, 4'd0, 1'b1, 4'hF, 4'd9, 32'hCAFE_F00D);
    step(1'b1, 4'd9, 1'b0, 4'h0, 4'd0, 32'd0);
    idle(12);

    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), $urandom);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'($urandom_range(4, 6)), 1'b1, 4'($urandom_range(0, 15)),
           4'($urandom_range(4, 6)), $urandom);
    end
    idle(5);

    chk("drain", 0, 32'(sb[0].size()), 32'd0);
    chk("drain", 1, 32'(sb[1].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
